gmii_tx_monitor: RTL and testbench

- Receive-side counterpart of the LMAC GMII transmitter. It sits on the MAC's gmii_txd/gmii_tx_en/gmii_tx_er outputs, as a bench monitor or a loopback sink.
- Per frame it strips preamble and SFD, packs frame bytes (DA through FCS) into a 64-bit AXI-Stream master, and checks CRC32.
- Emits a per-frame status pulse and maintains running counters.
- Runs at the 1G byte rate: one GMII byte per lclk.

---
 rtl/gmii_tx_monitor.sv | 266 ++++++++++++++++++++++++++
 tb/tb_gmii_tx_monitor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_monitor
// Description : GMII transmit-side sink. Strips preamble/SFD, packs frame
//               bytes into a 64-bit AXI-Stream master, checks the FCS and
//               reports per-frame status plus running frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_monitor #(
    parameter int MAX_FRAME = 16383,
    parameter int MIN_FRAME = 64
) (
    input  logic        lclk,
    input  logic        rst,
    input  logic [7:0]  gmii_txd,
    input  logic        gmii_tx_en,
    input  logic        gmii_tx_er,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic        crc_ok,
    output logic [4:0]  err_flags,
    output logic [15:0] frame_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [1:0]  c_idle      = 2'd0;
    localparam logic [1:0]  c_pre       = 2'd1;
    localparam logic [1:0]  c_data      = 2'd2;
    localparam logic [1:0]  c_drop      = 2'd3;
    localparam logic [31:0] c_residue   = 32'hC704DD7B;
    localparam logic [31:0] c_poly_refl = 32'hEDB88320;
    localparam logic [15:0] c_min_frame = 16'(MIN_FRAME);
    localparam logic [15:0] c_max_frame = 16'(MAX_FRAME);

    // Byte-serial reflected CRC32 (poly 0x04C11DB7, LSB first).
    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_poly_refl) : (c >> 1);
        end
        return c;
    endfunction

    logic [1:0]  r_state, w_state_nxt;
    logic        r_armed;
    logic [2:0]  r_pre_cnt;
    logic [63:0] r_word, r_hold;
    logic [2:0]  r_lane;
    logic        r_hold_v;
    logic [15:0] r_len;
    logic [31:0] r_crc, w_crc_rev;
    logic        r_txer, r_ovf;

    // Buffered word layout: {user, last, keep[7:0], data[63:0]}.
    logic [73:0] r_out_word, r_skid_word, w_push_word;
    logic        r_out_v, r_skid_v;
    logic        w_push, w_pop, w_drop;
    logic [63:0] w_push_data;
    logic [7:0]  w_push_keep;
    logic        w_push_last, w_push_user;

    logic        w_sfd, w_accept, w_end_data, w_end_drop;
    logic        w_runt, w_oversize, w_crc_ok, w_frame_err;

    logic        r_frame_done, r_crc_ok;
    logic [15:0] r_frame_len, r_frame_cnt, r_bad_cnt;
    logic [4:0]  r_err_flags;

    always_comb begin
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_crc_rev[i] = r_crc[31-i];
        end
    end

    assign w_sfd       = (r_state == c_pre) && gmii_tx_en && (gmii_txd == 8'hD5);
    assign w_accept    = (r_state == c_data) && gmii_tx_en;
    assign w_end_data  = (r_state == c_data) && !gmii_tx_en;
    assign w_end_drop  = (r_state == c_drop) && !gmii_tx_en;
    assign w_runt      = (r_len < c_min_frame);
    assign w_oversize  = (r_len > c_max_frame);
    assign w_crc_ok    = (w_crc_rev == c_residue);
    assign w_frame_err = r_ovf | w_oversize | w_runt | r_txer | !w_crc_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (r_armed && gmii_tx_en) begin
                    w_state_nxt = (gmii_txd == 8'h55) ? c_pre : c_drop;
                end
            end
            c_pre: begin
                if (!gmii_tx_en) begin
                    w_state_nxt = c_idle;
                end else if (gmii_txd == 8'hD5) begin
                    w_state_nxt = c_data;
                end else if (gmii_txd != 8'h55 || r_pre_cnt == 3'd7) begin
                    w_state_nxt = c_drop;
                end
            end
            c_data:  if (!gmii_tx_en) w_state_nxt = c_idle;
            default: if (!gmii_tx_en) w_state_nxt = c_idle;
        endcase
    end

    // A completed word waits one cycle in r_hold so its tlast is known.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = r_hold;
        w_push_keep = 8'hFF;
        w_push_last = 1'b0;
        w_push_user = 1'b0;
        if (r_state == c_data) begin
            if (r_hold_v) begin
                w_push      = 1'b1;
                w_push_last = !gmii_tx_en;
                w_push_user = !gmii_tx_en && w_frame_err;
            end else if (!gmii_tx_en && r_lane != 3'd0) begin
                w_push      = 1'b1;
                w_push_data = r_word;
                w_push_keep = ~(8'hFF << r_lane);
                w_push_last = 1'b1;
                w_push_user = w_frame_err;
            end
        end
    end

    assign w_push_word = {w_push_user, w_push_last, w_push_keep, w_push_data};
    assign w_pop       = r_out_v && m_axis_tready;
    assign w_drop      = w_push && r_out_v && r_skid_v && !w_pop;

    always_ff @(posedge lclk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_armed   <= 1'b0;
            r_pre_cnt <= 3'd0;
            r_word    <= '0;
            r_hold    <= '0;
            r_lane    <= 3'd0;
            r_hold_v  <= 1'b0;
            r_len     <= 16'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_txer    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= r_armed | !gmii_tx_en;
            if (r_state == c_idle) begin
                r_pre_cnt <= 3'd1;
            end else if (r_state == c_pre && gmii_txd == 8'h55) begin
                r_pre_cnt <= r_pre_cnt + 3'd1;
            end
            if (w_sfd) begin
                r_lane   <= 3'd0;
                r_hold_v <= 1'b0;
                r_len    <= 16'd0;
                r_crc    <= 32'hFFFFFFFF;
                r_txer   <= 1'b0;
                r_ovf    <= 1'b0;
            end else if (w_accept) begin
                if (r_lane == 3'd0) begin
                    r_word <= {56'd0, gmii_txd};
                end else begin
                    r_word[{r_lane, 3'b000} +: 8] <= gmii_txd;
                end
                if (r_lane == 3'd7) begin
                    r_hold <= {gmii_txd, r_word[55:0]};
                end
                r_hold_v <= (r_lane == 3'd7);
                r_lane   <= r_lane + 3'd1;
                if (r_len != 16'hFFFF) begin
                    r_len <= r_len + 16'd1;
                end
                r_crc <= f_crc_byte(r_crc, gmii_txd);
                if (gmii_tx_er) begin
                    r_txer <= 1'b1;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_hold_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge lclk) begin
        if (rst) begin
            r_out_v     <= 1'b0;
            r_skid_v    <= 1'b0;
            r_out_word  <= '0;
            r_skid_word <= '0;
        end else if (w_pop) begin
            if (r_skid_v) begin
                r_out_word <= r_skid_word;
                if (w_push) begin
                    r_skid_word <= w_push_word;
                end else begin
                    r_skid_v <= 1'b0;
                end
            end else if (w_push) begin
                r_out_word <= w_push_word;
            end else begin
                r_out_v <= 1'b0;
            end
        end else if (!r_out_v) begin
            if (w_push) begin
                r_out_word <= w_push_word;
                r_out_v    <= 1'b1;
            end
        end else if (!r_skid_v && w_push) begin
            r_skid_word <= w_push_word;
            r_skid_v    <= 1'b1;
        end
    end

    always_ff @(posedge lclk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_len  <= 16'd0;
            r_crc_ok     <= 1'b0;
            r_err_flags  <= 5'd0;
            r_frame_cnt  <= 16'd0;
            r_bad_cnt    <= 16'd0;
        end else begin
            r_frame_done <= w_end_data | w_end_drop;
            if (w_end_data) begin
                r_frame_len <= r_len;
                r_crc_ok    <= w_crc_ok;
                r_err_flags <= {r_ovf | w_drop, w_oversize, w_runt, r_txer, 1'b0};
                if (!(r_ovf | w_drop | w_oversize | w_runt | r_txer) && w_crc_ok) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_bad_cnt <= r_bad_cnt + 16'd1;
                end
            end else if (w_end_drop) begin
                r_frame_len <= 16'd0;
                r_crc_ok    <= 1'b0;
                r_err_flags <= 5'b00001;
                r_bad_cnt   <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tvalid = r_out_v;
    assign m_axis_tuser  = r_out_word[73];
    assign m_axis_tlast  = r_out_word[72];
    assign m_axis_tkeep  = r_out_word[71:64];
    assign m_axis_tdata  = r_out_word[63:0];
    assign frame_done    = r_frame_done;
    assign frame_len     = r_frame_len;
    assign crc_ok        = r_crc_ok;
    assign err_flags     = r_err_flags;
    assign frame_cnt     = r_frame_cnt;
    assign bad_cnt       = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmii_tx_monitor
// Description : Table-driven self-checking bench for gmii_tx_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_monitor;

    logic        lclk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_txd = 8'd0;
    logic        gmii_tx_en = 1'b0;
    logic        gmii_tx_er = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        crc_ok;
    logic [4:0]  err_flags;
    logic [15:0] frame_cnt;
    logic [15:0] bad_cnt;

    gmii_tx_monitor dut (
        .lclk(lclk), .rst(rst), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_done(frame_done), .frame_len(frame_len),
        .crc_ok(crc_ok), .err_flags(err_flags), .frame_cnt(frame_cnt), .bad_cnt(bad_cnt)
    );

    always #4 lclk = ~lclk;

    typedef struct {
        string      name;
        int         pre_n;
        logic [7:0] sfd;
        int         dlen;
        int         er_pos;
        bit         bad_fcs;
        bit         add_fcs;
        int         mode;
        bit         chk_data;
        int         exp_len;
        bit         exp_crc;
        logic [4:0] exp_err;
        int         exp_words;
        logic [7:0] exp_keep;
        bit         exp_user;
    } vec_t;

    vec_t       vecs[11];
    int         checks = 0;
    int         failures = 0;
    int         exp_good = 0;
    int         exp_bad = 0;

    int         mon_words = 0;
    int         mon_done = 0;
    bit         mon_last = 0;
    logic [7:0] mon_keep = 8'd0;
    bit         mon_user = 0;
    logic [15:0] mon_len = 16'd0;
    logic       mon_crc = 1'b0;
    logic [4:0] mon_err = 5'd0;
    int         stab_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic rdy(input int mode, input int rel);
        if (mode == 1) return (rel % 8 == 7);
        if (mode == 2) return !(rel >= 14 && rel < 34);
        return 1'b1;
    endfunction

    // Sample between the falling and rising edges, after the driver has settled.
    logic [73:0] prev_word = '0;
    bit          prev_stall = 0;
    initial begin
        forever begin
            @(negedge lclk);
            #1;
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall && !(m_axis_tvalid &&
                    {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} == prev_word))
                    stab_err++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
                if (m_axis_tvalid && m_axis_tready) begin
                    mon_words++;
                    for (int i = 0; i < 8; i++)
                        if (m_axis_tkeep[i]) rx_q.push_back(m_axis_tdata[8*i +: 8]);
                    if (m_axis_tlast) begin
                        mon_last = 1;
                        mon_keep = m_axis_tkeep;
                        mon_user = m_axis_tuser;
                    end
                end
                if (frame_done) begin
                    mon_done++;
                    mon_len = frame_len;
                    mon_crc = crc_ok;
                    mon_err = err_flags;
                end
            end
        end
    end

    task automatic clear_mon();
        mon_words = 0;
        mon_done  = 0;
        mon_last  = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_frame(input int pre_n, input logic [7:0] sfd, input int dlen,
                               input int er_pos, input bit bad_fcs, input bit add_fcs,
                               input int mode, input bit record, inout int rel);
        logic [7:0]  q[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < pre_n; i++) q.push_back(8'h55);
        q.push_back(sfd);
        for (int i = 0; i < dlen; i++) begin
            b = i[7:0];
            q.push_back(b);
            crc = crc_upd(crc, b);
        end
        if (add_fcs) begin
            fcs = ~crc;
            if (bad_fcs) fcs[31:24] = ~fcs[31:24];
            for (int j = 0; j < 4; j++) q.push_back(fcs[8*j +: 8]);
        end
        if (record)
            for (int k = pre_n + 1; k < q.size(); k++) exp_q.push_back(q[k]);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge lclk);
            gmii_tx_en    = 1'b1;
            gmii_txd      = q[k];
            gmii_tx_er    = (er_pos >= 0) && (k == pre_n + 1 + er_pos);
            m_axis_tready = rdy(mode, rel);
            rel++;
        end
        @(negedge lclk);
        gmii_tx_en    = 1'b0;
        gmii_txd      = 8'd0;
        gmii_tx_er    = 1'b0;
        m_axis_tready = rdy(mode, rel);
        rel++;
    endtask

    task automatic wait_done(input string nm, input int n, input bit need_last,
                             input int mode, inout int rel);
        int c;
        c = 0;
        while (!(mon_done >= n && (mon_last || !need_last)) && c < 400) begin
            @(negedge lclk);
            m_axis_tready = rdy(mode, rel);
            rel++;
            c++;
        end
        check({nm, " wait"}, 64'(c < 400), 64'd1);
        repeat (6) begin
            @(negedge lclk);
            m_axis_tready = rdy(mode, rel);
            rel++;
        end
    endtask

    task automatic check_data(input string nm);
        bit ok;
        ok = (rx_q.size() == exp_q.size());
        if (ok)
            for (int i = 0; i < rx_q.size(); i++)
                if (rx_q[i] !== exp_q[i]) ok = 0;
        check({nm, " data"}, 64'(ok), 64'd1);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " tdata"}, m_axis_tdata, 64'd0);
        check({nm, " ctl"}, {m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                              frame_done, crc_ok, err_flags}, 64'd0);
        check({nm, " cnt"}, {frame_len, frame_cnt, bad_cnt}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int rel;
        rel = 0;
        clear_mon();
        drive_frame(v.pre_n, v.sfd, v.dlen, v.er_pos, v.bad_fcs, v.add_fcs, v.mode,
                    v.chk_data, rel);
        wait_done(v.name, 1, v.exp_words > 0, v.mode, rel);
        check({v.name, " done"}, 64'(mon_done), 64'd1);
        check({v.name, " len"}, 64'(mon_len), 64'(v.exp_len));
        check({v.name, " crc_ok"}, 64'(mon_crc), 64'(v.exp_crc));
        check({v.name, " err"}, 64'(mon_err), 64'(v.exp_err));
        check({v.name, " words"}, 64'(mon_words), 64'(v.exp_words));
        if (v.exp_words > 0) begin
            check({v.name, " keep"}, 64'(mon_keep), 64'(v.exp_keep));
            check({v.name, " tuser"}, 64'(mon_user), 64'(v.exp_user));
        end
        if (v.chk_data) check_data(v.name);
        if (v.exp_err == 5'd0 && v.exp_crc) exp_good++;
        else exp_bad++;
        check({v.name, " frame_cnt"}, 64'(frame_cnt), 64'(exp_good));
        check({v.name, " bad_cnt"}, 64'(bad_cnt), 64'(exp_bad));
    endtask

    initial begin
        int rel;
        //         name        pre sfd    dlen er  bad fcs mode dat  len crc err       wrd keep  usr
        vecs[0]  = '{"good64",   7, 8'hD5, 60, -1, 0, 1, 0, 1,  64, 1, 5'b00000,  8, 8'hFF, 0};
        vecs[1]  = '{"good65",   7, 8'hD5, 61, -1, 0, 1, 0, 1,  65, 1, 5'b00000,  9, 8'h01, 0};
        vecs[2]  = '{"badfcs",   7, 8'hD5, 60, -1, 1, 1, 0, 1,  64, 0, 5'b00000,  8, 8'hFF, 1};
        vecs[3]  = '{"txer",     7, 8'hD5, 60, 20, 0, 1, 0, 1,  64, 1, 5'b00010,  8, 8'hFF, 1};
        vecs[4]  = '{"prebad",   1, 8'h54, 60, -1, 0, 1, 0, 0,   0, 0, 5'b00001,  0, 8'h00, 0};
        vecs[5]  = '{"toggle",   7, 8'hD5, 124, -1, 0, 1, 1, 1, 128, 1, 5'b00000, 16, 8'hFF, 0};
        vecs[6]  = '{"stall20",  7, 8'hD5, 124, -1, 0, 1, 2, 0, 128, 1, 5'b10000, 15, 8'hFF, 1};
        vecs[7]  = '{"pre1",     1, 8'hD5, 60, -1, 0, 1, 0, 1,  64, 1, 5'b00000,  8, 8'hFF, 0};
        vecs[8]  = '{"pre8",     8, 8'hD5, 60, -1, 0, 1, 0, 0,   0, 0, 5'b00001,  0, 8'h00, 0};
        vecs[9]  = '{"zerolen",  7, 8'hD5,  0, -1, 0, 0, 0, 0,   0, 0, 5'b00100,  0, 8'h00, 0};
        vecs[10] = '{"runt63",   7, 8'hD5, 59, -1, 0, 1, 0, 1,  63, 1, 5'b00100,  8, 8'h7F, 1};

        repeat (3) @(negedge lclk);
        #2;
        check_zero("reset");
        @(negedge lclk);
        rst = 1'b0;
        repeat (2) @(negedge lclk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Two minimum-gap frames back to back.
        clear_mon();
        rel = 0;
        drive_frame(7, 8'hD5, 60, -1, 0, 1, 0, 1, rel);
        drive_frame(7, 8'hD5, 60, -1, 0, 1, 0, 1, rel);
        wait_done("b2b", 2, 1, 0, rel);
        check("b2b done", 64'(mon_done), 64'd2);
        check("b2b words", 64'(mon_words), 64'd16);
        check("b2b len", 64'(mon_len), 64'd64);
        check("b2b status", {mon_crc, mon_err}, {1'b1, 5'd0});
        check_data("b2b");
        exp_good += 2;
        check("b2b frame_cnt", 64'(frame_cnt), 64'(exp_good));

        // Reset in the middle of a third frame, with tx_en held high through it.
        clear_mon();
        for (int k = 0; k < 28; k++) begin
            @(negedge lclk);
            gmii_tx_en = 1'b1;
            gmii_txd   = (k < 7) ? 8'h55 : (k == 7) ? 8'hD5 : 8'hA5;
            m_axis_tready = 1'b1;
        end
        @(negedge lclk);
        rst = 1'b1;
        @(negedge lclk);
        @(negedge lclk);
        #2;
        check_zero("midrst");
        @(negedge lclk);
        rst = 1'b0;
        clear_mon();
        for (int k = 0; k < 12; k++) begin
            @(negedge lclk);
            gmii_txd = (k < 7) ? 8'h55 : 8'hD5;
        end
        @(negedge lclk);
        gmii_tx_en = 1'b0;
        gmii_txd   = 8'd0;
        repeat (12) @(negedge lclk);
        check("midrst words", 64'(mon_words), 64'd0);
        check("midrst done", 64'(mon_done), 64'd0);
        exp_good = 0;
        exp_bad  = 0;
        run_vec(vecs[0]);

        check("stable", 64'(stab_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
